// File: rtl/led_pwm_pkg.sv
// ---------------------------------------------------------------------------
// led_pwm_pkg
// Shared constants for the PicoBlaze LED PWM bank.
//   - Register offsets above the duty block. The duty registers occupy
//     offsets 0..NUM_CH-1, and CTRL and STATUS follow at NUM_CH+CTRL_OFS and
//     NUM_CH+STATUS_OFS.
//   - CTRL bit positions.
//   - The default prescale value. At 50 MHz, 195 cycles per step with
//     256 steps gives a PWM period of about 1 kHz.
//   - A helper function that maps a port_id to a register offset.
// The optional fade feature is enabled by defining LED_PWM_FADE_EN.
// ---------------------------------------------------------------------------
package led_pwm_pkg;

    localparam int CTRL_OFS         = 0;
    localparam int STATUS_OFS       = 1;

    localparam int EN_BIT           = 0;
    localparam int MODE_BIT         = 1;
    localparam int FADE_BIT         = 2;

    localparam int DEFAULT_PRESCALE = 195;

    // The offset wraps modulo 256. A port_id below the base therefore maps to
    // a large offset, and that offset falls outside the register map.
    function automatic logic [7:0] reg_offset(input logic [7:0] port_id,
                                              input logic [7:0] base);
        return port_id - base;
    endfunction

endpackage

// File: rtl/led_pwm_channel.sv
// ---------------------------------------------------------------------------
// led_pwm_channel
// One LED channel. It holds the software-visible duty (shadow) and the duty
// that the comparator uses (active). It also produces one registered LED bit.
// Ports:
//   clk, reset    system clock and synchronous active-high reset
//   wr_en         load shadow from wr_data on this cycle
//   wr_data       new duty value
//   period_end    last count step of the PWM period
//   pwm_cnt       shared PWM counter
//   en, mode      CTRL enable, and mode select (0 = PWM, 1 = on/off)
//   fade          step active toward shadow instead of jumping; the top
//                 level ties this low unless LED_PWM_FADE_EN is defined
//   shadow        current duty register, used for readback
//   led           registered LED output
// ---------------------------------------------------------------------------
module led_pwm_channel
    import led_pwm_pkg::*;
#(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [PWM_BITS-1:0] wr_data,
    input  logic                period_end,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    input  logic                en,
    input  logic                mode,
    input  logic                fade,
    output logic [PWM_BITS-1:0] shadow,
    output logic                led
);

    logic [PWM_BITS-1:0] active;

    // Duty double buffer.
    // Software always writes the shadow register. The comparator only sees
    // the duty once it has been copied into active at a period boundary.
    // Active still holds the old shadow value when the copy happens. A write
    // on the same cycle as period_end therefore waits one full period.
    // While the bank is disabled, active tracks shadow continuously. Enabling
    // the bank then starts cleanly with the duties that software programmed.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow <= '0;
            active <= '0;
        end else begin
            if (wr_en) begin
                shadow <= wr_data;
            end
            if (!en) begin
                active <= shadow;
            end else if (period_end) begin
                if (fade) begin
                    if (active < shadow) begin
                        active <= active + 1'b1;
                    end else if (active > shadow) begin
                        active <= active - 1'b1;
                    end
                end else begin
                    active <= shadow;
                end
            end
        end
    end

    // LED output register.
    // In PWM mode, the LED is on while the count is below the active duty.
    // Duty 0 is therefore always off. The maximum duty is on for every step
    // except the last. In on/off mode, the LED reacts to the shadow value
    // directly, so software gets an immediate response.
    always_ff @(posedge clk) begin
        if (reset) begin
            led <= 1'b0;
        end else begin
            led <= en & (mode ? (shadow != '0) : (pwm_cnt < active));
        end
    end

endmodule

// File: rtl/picoblaze_led_pwm_bank.sv
// ---------------------------------------------------------------------------
// picoblaze_led_pwm_bank
// kcpsm3 output peripheral that drives NUM_CH PWM LED lines.
// Port map (offset = port_id - BASE_PORT_ID):
//   0..NUM_CH-1   duty registers (R/W)
//   NUM_CH        CTRL (R/W): bit0 EN, bit1 MODE, bit2 FADE (LED_PWM_FADE_EN only)
//   NUM_CH+1      STATUS (RO): current PWM count
// Ports:
//   clk, reset    system clock and synchronous active-high reset
//   port_id       kcpsm3 port address
//   write_strobe  kcpsm3 write strobe
//   out_port      kcpsm3 write data
//   in_port       registered readback of the register that port_id selects
//   led           registered PWM LED outputs
// Optional build macro: LED_PWM_FADE_EN adds the FADE control bit.
// ---------------------------------------------------------------------------
module picoblaze_led_pwm_bank
    import led_pwm_pkg::*;
#(
    parameter int         NUM_CH       = 8,
    parameter logic [7:0] BASE_PORT_ID = 8'h00,
    parameter int         PWM_BITS     = 8,
    parameter int         PRESCALE     = DEFAULT_PRESCALE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        port_id,
    input  logic              write_strobe,
    input  logic [7:0]        out_port,
    output logic [7:0]        in_port,
    output logic [NUM_CH-1:0] led
);

    localparam int             PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

    logic [7:0]          offset;
    logic [PRE_W-1:0]    pre_cnt;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                tick;
    logic                period_end;
    logic                ctrl_en;
    logic                ctrl_mode;
    logic                ctrl_fade;
    logic                ctrl_wr;
    logic [NUM_CH-1:0]   wr_en;
    logic [PWM_BITS-1:0] shadow [NUM_CH];
    logic [7:0]          rd_data;
    logic                unused_port_bits;

    assign offset           = reg_offset(port_id, BASE_PORT_ID);
    assign ctrl_wr          = write_strobe && (offset == 8'(NUM_CH + CTRL_OFS));
    assign tick             = ctrl_en && (pre_cnt == PRE_LAST);
    assign period_end       = tick && (pwm_cnt == '1);
    assign unused_port_bits = ^out_port;

    // Address decode for the duty registers.
    // Each channel gets a one-hot write enable. Offsets outside the duty block
    // leave every channel untouched.
    always_comb begin
        wr_en = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (write_strobe && (offset == 8'(i))) begin
                wr_en[i] = 1'b1;
            end
        end
    end

    // Control register.
    // Only the EN and MODE bits exist in the base build. FADE is stored only
    // when the fade option is compiled in. Otherwise FADE is a constant zero,
    // so it reads back as 0 and the channels always jump to the new duty.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_en   <= 1'b0;
            ctrl_mode <= 1'b0;
        end else if (ctrl_wr) begin
            ctrl_en   <= out_port[EN_BIT];
            ctrl_mode <= out_port[MODE_BIT];
        end
    end

`ifdef LED_PWM_FADE_EN
    // The fade enable bit is stored alongside EN and MODE.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_fade <= 1'b0;
        end else if (ctrl_wr) begin
            ctrl_fade <= out_port[FADE_BIT];
        end
    end
`else
    assign ctrl_fade = 1'b0;
`endif

    // Prescaler and PWM counter.
    // Both counters are held at zero while the bank is disabled. Enabling the
    // bank therefore always begins a fresh period. pwm_cnt wraps naturally at
    // 2^PWM_BITS.
    always_ff @(posedge clk) begin
        if (reset || !ctrl_en) begin
            pre_cnt <= '0;
            pwm_cnt <= '0;
        end else begin
            if (tick) begin
                pre_cnt <= '0;
                pwm_cnt <= pwm_cnt + 1'b1;
            end else begin
                pre_cnt <= pre_cnt + 1'b1;
            end
        end
    end

    // Readback multiplexer.
    // All values are zero-extended to the 8-bit port. Any offset outside the
    // register map reads as zero.
    always_comb begin
        rd_data = 8'h00;
        for (int i = 0; i < NUM_CH; i++) begin
            if (offset == 8'(i)) begin
                rd_data = 8'(shadow[i]);
            end
        end
        if (offset == 8'(NUM_CH + CTRL_OFS)) begin
            rd_data[EN_BIT]   = ctrl_en;
            rd_data[MODE_BIT] = ctrl_mode;
            rd_data[FADE_BIT] = ctrl_fade;
        end
        if (offset == 8'(NUM_CH + STATUS_OFS)) begin
            rd_data = 8'(pwm_cnt);
        end
    end

    // The readback register runs every cycle and does not need read_strobe.
    // kcpsm3 holds port_id for two cycles, so the data is ready in time.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_port <= 8'h00;
        end else begin
            in_port <= rd_data;
        end
    end

    // One channel per LED line.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        led_pwm_channel #(
            .PWM_BITS (PWM_BITS)
        ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .wr_en      (wr_en[g]),
            .wr_data    (out_port[PWM_BITS-1:0]),
            .period_end (period_end),
            .pwm_cnt    (pwm_cnt),
            .en         (ctrl_en),
            .mode       (ctrl_mode),
            .fade       (ctrl_fade),
            .shadow     (shadow[g]),
            .led        (led[g])
        );
    end

endmodule

// File: tb/tb_picoblaze_led_pwm_bank.sv
// ---------------------------------------------------------------------------
// tb_picoblaze_led_pwm_bank
// Self-checking bench for picoblaze_led_pwm_bank. It uses four channels at
// base port 0x10, 8-bit PWM and PRESCALE=1.
// The reference model works from the register-map rules: duty and CTRL
// values, a cycle count, and period boundaries. The bench compares every
// cycle against this model. Directed checks count the LED on-time over whole
// periods and compare the counts against constants.
// ---------------------------------------------------------------------------
module tb_picoblaze_led_pwm_bank;

    localparam int         NUM_CH   = 4;
    localparam logic [7:0] BASE     = 8'h10;
    localparam int         PWM_BITS = 8;
    localparam int         PRESCALE = 1;
    localparam int         STEPS    = 1 << PWM_BITS;
    localparam logic [7:0] CTRL_ID  = BASE + 8'(NUM_CH);
    localparam logic [7:0] STAT_ID  = BASE + 8'(NUM_CH + 1);

    logic              clk = 1'b0;
    logic              reset;
    logic [7:0]        port_id;
    logic              write_strobe;
    logic [7:0]        out_port;
    logic [7:0]        in_port;
    logic [NUM_CH-1:0] led;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    int m_pre, m_cnt, m_en, m_mode, m_fade;
    int m_shadow [NUM_CH];
    int m_active [NUM_CH];
    int m_led, m_in;
    int hi_cnt   [NUM_CH];

    always #5 clk = ~clk;

    picoblaze_led_pwm_bank #(
        .NUM_CH       (NUM_CH),
        .BASE_PORT_ID (BASE),
        .PWM_BITS     (PWM_BITS),
        .PRESCALE     (PRESCALE)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .port_id      (port_id),
        .write_strobe (write_strobe),
        .out_port     (out_port),
        .in_port      (in_port),
        .led          (led)
    );

    // Counts one comparison and reports it when it does not match.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     tag, actual, expected, $time);
        end
    endtask

    // Advances the model by one clock edge.
    // The model uses the register-map rules and the inputs of that edge.
    task automatic modelStep(input logic rst, input logic [7:0] pid,
                             input logic ws, input logic [7:0] data);
        int ofs, tick, pend, n_led, n_in;
        if (rst) begin
            m_pre = 0; m_cnt = 0; m_en = 0; m_mode = 0; m_fade = 0;
            m_led = 0; m_in = 0;
            for (int i = 0; i < NUM_CH; i++) begin
                m_shadow[i] = 0;
                m_active[i] = 0;
            end
            return;
        end
        ofs  = (int'(pid) - int'(BASE) + 256) % 256;
        tick = (m_en != 0 && m_pre == PRESCALE - 1) ? 1 : 0;
        pend = (tick != 0 && m_cnt == STEPS - 1) ? 1 : 0;
        n_led = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (m_en != 0) begin
                if (m_mode != 0) begin
                    if (m_shadow[i] != 0) n_led |= (1 << i);
                end else begin
                    if (m_cnt < m_active[i]) n_led |= (1 << i);
                end
            end
        end
        n_in = 0;
        if (ofs < NUM_CH)          n_in = m_shadow[ofs];
        else if (ofs == NUM_CH)    n_in = m_en + 2 * m_mode + 4 * m_fade;
        else if (ofs == NUM_CH + 1) n_in = m_cnt;
        for (int i = 0; i < NUM_CH; i++) begin
            if (m_en == 0) begin
                m_active[i] = m_shadow[i];
            end else if (pend != 0) begin
                if (m_fade != 0) begin
                    if (m_active[i] < m_shadow[i])      m_active[i] = m_active[i] + 1;
                    else if (m_active[i] > m_shadow[i]) m_active[i] = m_active[i] - 1;
                end else begin
                    m_active[i] = m_shadow[i];
                end
            end
        end
        if (m_en == 0) begin
            m_pre = 0;
            m_cnt = 0;
        end else if (tick != 0) begin
            m_pre = 0;
            m_cnt = (m_cnt + 1) % STEPS;
        end else begin
            m_pre = m_pre + 1;
        end
        if (ws && ofs < NUM_CH) m_shadow[ofs] = int'(data) % STEPS;
        if (ws && ofs == NUM_CH) begin
            m_en   = int'(data[0]);
            m_mode = int'(data[1]);
`ifdef LED_PWM_FADE_EN
            m_fade = int'(data[2]);
`endif
        end
        m_led = n_led;
        m_in  = n_in;
    endtask

    // Drives one bus cycle and steps the model. The outputs are then checked
    // on the falling edge.
    task automatic applyStimulus(input logic rst, input logic [7:0] pid,
                                 input logic ws, input logic [7:0] data);
        reset        = rst;
        port_id      = pid;
        write_strobe = ws;
        out_port     = data;
        @(posedge clk);
        modelStep(rst, pid, ws, data);
        @(negedge clk);
        checkOutput("led", 32'(led), 32'(m_led));
        checkOutput("in_port", 32'(in_port), 32'(m_in));
    endtask

    task automatic writeReg(input int ofs, input logic [7:0] data);
        applyStimulus(1'b0, BASE + 8'(ofs), 1'b1, data);
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) applyStimulus(1'b0, STAT_ID, 1'b0, 8'h00);
    endtask

    // Idles until the model count reaches target. The wait is bounded.
    task automatic waitCnt(input int target);
        int guard = 0;
        while (m_cnt != target && guard < 4 * STEPS) begin
            idle(1);
            guard++;
        end
        if (m_cnt != target) checkOutput("wait_timeout", 32'(m_cnt), 32'(target));
    endtask

    // Counts the LED on-cycles of each channel over one full period.
    task automatic countWindow();
        for (int i = 0; i < NUM_CH; i++) hi_cnt[i] = 0;
        for (int c = 0; c < STEPS * PRESCALE; c++) begin
            idle(1);
            for (int i = 0; i < NUM_CH; i++) hi_cnt[i] += int'(led[i]);
        end
    endtask

    initial begin
        logic [7:0] exp_rd [NUM_CH+1];
        $display("[TB] starting LED PWM bank bench");

        // Reset, then read every port_id. All values read back as zero.
        applyStimulus(1'b1, 8'h00, 1'b0, 8'h00);
        applyStimulus(1'b1, 8'h00, 1'b0, 8'h00);
        checkOutput("rst_led", 32'(led), 32'h0);
        checkOutput("rst_in_port", 32'(in_port), 32'h0);
        for (int p = 0; p < 256; p++) applyStimulus(1'b0, 8'(p), 1'b0, 8'h00);

        // A write while disabled leaves the LEDs off. Readback has one cycle
        // of latency.
        writeReg(0, 8'h80);
        applyStimulus(1'b0, BASE, 1'b0, 8'h00);
        checkOutput("rd_ch0", 32'(in_port), 32'h80);
        checkOutput("dis_led", 32'(led), 32'h0);

        // PWM duties over one full period.
        writeReg(0, 8'h40);
        writeReg(1, 8'h00);
        writeReg(2, 8'hFF);
        writeReg(3, 8'h20);
        writeReg(NUM_CH, 8'h01);
        countWindow();
        checkOutput("hi_ch0_40", 32'(hi_cnt[0]), 32'd64);
        checkOutput("hi_ch1_00", 32'(hi_cnt[1]), 32'd0);
        checkOutput("hi_ch2_ff", 32'(hi_cnt[2]), 32'd255);
        checkOutput("hi_ch3_20", 32'(hi_cnt[3]), 32'd32);

        // A mid-period write applies from the next period onward.
        waitCnt(100);
        writeReg(0, 8'h10);
        waitCnt(0);
        countWindow();
        checkOutput("hi_ch0_mid", 32'(hi_cnt[0]), 32'd16);

        // A write on the same cycle as period_end lands one period later.
        waitCnt(STEPS - 1);
        writeReg(0, 8'h30);
        countWindow();
        checkOutput("hi_ch0_coinc_old", 32'(hi_cnt[0]), 32'd16);
        countWindow();
        checkOutput("hi_ch0_coinc_new", 32'(hi_cnt[0]), 32'd48);

        // In on/off mode, the LED follows the shadow value immediately.
        writeReg(NUM_CH, 8'h03);
        writeReg(3, 8'h01);
        idle(1);
        checkOutput("mode_on", 32'(led[3]), 32'd1);
        writeReg(3, 8'h00);
        idle(1);
        checkOutput("mode_off", 32'(led[3]), 32'd0);

        // STATUS stays at zero while the bank is disabled.
        writeReg(NUM_CH, 8'h02);
        idle(3);
        checkOutput("status_dis", 32'(in_port), 32'h0);

        // Writes outside the map change nothing.
        writeReg(NUM_CH + 2, 8'hAA);
        applyStimulus(1'b0, BASE - 8'd1, 1'b1, 8'h55);
        exp_rd[0] = 8'h30; exp_rd[1] = 8'h00; exp_rd[2] = 8'hFF;
        exp_rd[3] = 8'h00; exp_rd[4] = 8'h02;
        for (int r = 0; r <= NUM_CH; r++) begin
            applyStimulus(1'b0, BASE + 8'(r), 1'b0, 8'h00);
            checkOutput($sformatf("rd_after_bad_%0d", r), 32'(in_port), 32'(exp_rd[r]));
        end

        // A reset mid-period clears everything on the next cycle.
        writeReg(NUM_CH, 8'h01);
        idle(50);
        applyStimulus(1'b1, STAT_ID, 1'b0, 8'h00);
        checkOutput("midrst_led", 32'(led), 32'h0);
        checkOutput("midrst_in_port", 32'(in_port), 32'h0);
        applyStimulus(1'b0, BASE + 8'd2, 1'b0, 8'h00);
        checkOutput("midrst_ch2", 32'(in_port), 32'h0);
        applyStimulus(1'b0, CTRL_ID, 1'b0, 8'h00);
        checkOutput("midrst_ctrl", 32'(in_port), 32'h0);

`ifdef LED_PWM_FADE_EN
        // With fade on, the duty steps one count per period from 0 up to 4.
        writeReg(NUM_CH, 8'h05);
        writeReg(0, 8'h04);
        waitCnt(0);
        for (int k = 1; k <= 5; k++) begin
            countWindow();
            checkOutput($sformatf("fade_step_%0d", k), 32'(hi_cnt[0]),
                        32'((k < 4) ? k : 4));
        end
`endif

        // Randomized bus traffic, checked against the model every cycle.
        for (int c = 0; c < 4000; c++) begin
            logic [7:0] pid, data;
            logic       ws, rst;
            pid  = 8'(int'(BASE) - 2 + int'($urandom_range(0, NUM_CH + 5)));
            ws   = ($urandom_range(0, 3) == 0);
            data = 8'($urandom);
            if (pid == CTRL_ID) data[0] = ($urandom_range(0, 3) != 0);
            rst  = ($urandom_range(0, 799) == 0);
            applyStimulus(rst, pid, ws, data);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/picoblaze_led_pwm_bank.md
Name: picoblaze_led_pwm_bank

Overview:
- Parametrised PicoBlaze (kcpsm3) output peripheral; successor to the single fixed-ID 8-bit output register.
- Drives NUM_CH LED lines, each with its own port-mapped PWM duty register, plus a control register and registered readback onto in_port.
- Sits between the kcpsm3 port bus and the board LEDs.
- Duty updates are double-buffered so changes never glitch mid-period.

Parameters:
- NUM_CH, 8, number of LED channels (1..8)
- BASE_PORT_ID, 8'h00, port ID of channel 0 duty register; channel i at BASE_PORT_ID+i
- PWM_BITS, 8, PWM resolution in bits (1..8)
- PRESCALE, 195, clk cycles per PWM count step (>=1); 50 MHz/195/256 is approx. 1 kHz period

Ports:
- clk  in  1  system clock (CLK_50M domain)
- reset  in  1  synchronous, active-high reset
- port_id  in  8  kcpsm3 port_id
- write_strobe  in  1  kcpsm3 write_strobe
- out_port  in  8  kcpsm3 out_port
- in_port  out  8  registered readback data to kcpsm3 in_port
- led  out  NUM_CH  PWM LED outputs, registered

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port named reset.
- Reset: shadow[i]=0, active[i]=0, ctrl=0, pre_cnt=0, pwm_cnt=0, led=0, in_port=8'h00. Reset mid-period aborts the period immediately.
- Register map (offset = port_id - BASE_PORT_ID, 8-bit unsigned):
  - 0..NUM_CH-1: duty shadow, R/W
  - NUM_CH: CTRL, R/W; bit0 EN, bit1 MODE (0=PWM, 1=on/off)
  - NUM_CH+1: STATUS, RO; value = pwm_cnt zero-extended
  - Any other port_id: writes ignored, reads return 8'h00.
  - BASE_PORT_ID+NUM_CH+1 must not exceed 8'hFF; fixed by parameter choice, not checked in RTL.
- Write: on a cycle with write_strobe=1 and a matching offset, the register loads out_port. Duty registers load out_port[PWM_BITS-1:0]; CTRL loads out_port[1:0]. Takes effect the next cycle.
- Readback: in_port is registered every cycle from the current port_id, independent of read_strobe, with 1-cycle latency. This is valid for kcpsm3, which holds port_id for 2 cycles. Values are zero-extended to 8 bits.
- Prescaler: pre_cnt counts 0..PRESCALE-1; tick=1 when pre_cnt==PRESCALE-1. With PRESCALE=1, tick=1 every cycle.
- PWM counter: on tick, pwm_cnt increments modulo 2^PWM_BITS. period_end = tick && pwm_cnt==2^PWM_BITS-1.
- Double buffer: on period_end, active[i] <= shadow[i].
  - If a duty write and period_end coincide, active takes the pre-write shadow; the new value applies at the next period_end.
- Output, registered, 1 cycle after pwm_cnt/active:
  - EN=0: led=0.
  - EN=1, MODE=0: led[i] = (pwm_cnt < active[i]). Duty 0 is always off; duty max is on for (2^PWM_BITS-1)/2^PWM_BITS of the period.
  - EN=1, MODE=1: led[i] = (shadow[i] != 0), immediate, no buffering.
- Disabled (EN=0): pre_cnt and pwm_cnt held at 0; active[i] follows shadow[i] every cycle. Enabling therefore starts a fresh period with current duties.
- Writing CTRL does not alter any duty register.

Optional Feature:
- Macro: LED_PWM_FADE_EN.
- Defined: CTRL bit2 FADE becomes R/W. When FADE=1, at each period_end active[i] steps by 1 toward shadow[i] (+1 if less, -1 if greater, hold if equal) instead of jumping. FADE=0 behaves as the base design.
- Undefined: CTRL bit2 is not stored and reads 0; active always loads shadow directly.

Decomposition:
- Shared package, led_pwm_pkg: register offsets relative to NUM_CH (CTRL_OFS, STATUS_OFS), CTRL bit positions (EN_BIT, MODE_BIT, FADE_BIT), default PRESCALE constant.
- One sub-module, led_pwm_channel: holds shadow/active for one channel, takes a write enable, period_end, pwm_cnt, EN and MODE, and produces one led bit. The top level instantiates it NUM_CH times via generate, and holds the prescaler, pwm_cnt, CTRL and readback mux.

Test Plan:
- Reset then idle: led=0; in_port=00 for every port_id; write BASE+0=0x80 with EN=0 -> led stays 0; read BASE+0 -> in_port=0x80 one cycle after port_id is set.
- PRESCALE=1, PWM_BITS=8, EN=1, duty ch0=0x40, ch1=0x00, ch2=0xFF -> per 256-cycle period: ch0 high 64 cycles, ch1 never, ch2 high 255 cycles.
- Write ch0=0x10 mid-period while running 0x40 -> current period completes at 64 high; next period 16 high. Write coinciding with period_end -> change lands one period later.
- MODE=1, duty ch3=0x01 -> led[3]=1 the cycle after the write registers; duty ch3=0 -> led[3]=0; STATUS stays 0 while EN=0.
- Writes to BASE+NUM_CH+2 and to BASE-1 -> no register changes; assert reset mid-period -> all outputs and registers 0 the next cycle.
- LED_PWM_FADE_EN with FADE=1, active 0x00, shadow 0x04 -> active reaches 0x04 after exactly 4 period_ends, one step each.
